// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Stream handshake: a byte moves on a rising edge where in_valid and in_ready are both high;
// in_valid without in_ready has no effect and the source may change in_data freely while in_valid is low.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed, XOR-checksummed byte stream and writes
// little-endian 32-bit words into instruction memory, then raises start or error.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    imem_loader_if.slave bus,
    output logic         start,
    output logic         busy,
    output logic         error,
    output logic [15:0]  words_loaded,
    output logic [2:0]   state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_sr_q;
    logic [7:0]  csum_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] words_q;

    logic        accepting;
    logic        xfer;
    logic        restart;
    logic [15:0] len_full;
    logic        len_too_big;
    logic        last_word;

    assign accepting   = (state_q == LEN0) || (state_q == LEN1) ||
                         (state_q == DATA) || (state_q == CSUM);
    assign xfer        = accepting && bus.in_valid;
    assign restart     = load_req &&
                         ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    // Full word count as it becomes known during the LEN1 transfer.
    assign len_full    = {bus.in_data, n_q[7:0]};
    assign len_too_big = ({1'b0, len_full} > DEPTH_LIMIT);
    assign last_word   = (word_idx_q == (n_q - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (load_req) state_d = LEN0;
            end
            LEN0: begin
                if (xfer) state_d = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if (len_too_big)            state_d = ERROR;
                    else if (len_full == 16'd0) state_d = CSUM;
                    else                        state_d = DATA;
                end
            end
            DATA: begin
                if (xfer && (byte_cnt_q == 2'd3) && last_word) state_d = CSUM;
            end
            CSUM: begin
                if (xfer) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word assembly, checksum and the registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= 16'd0;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_sr_q  <= 24'd0;
            csum_q     <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            words_q    <= 16'd0;
        end else begin
            we_q <= 1'b0;
            if (restart) begin
                n_q        <= 16'd0;
                word_idx_q <= 16'd0;
                byte_cnt_q <= 2'd0;
                csum_q     <= 8'd0;
                words_q    <= 16'd0;
            end
            if (xfer) begin
                case (state_q)
                    LEN0: n_q[7:0]  <= bus.in_data;
                    LEN1: n_q[15:8] <= bus.in_data;
                    DATA: begin
                        csum_q     <= csum_q ^ bus.in_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        word_sr_q  <= {bus.in_data, word_sr_q[23:8]};
                        if (byte_cnt_q == 2'd3) begin
                            // Shift register now holds {b2,b1,b0}; this byte is b3.
                            we_q       <= 1'b1;
                            wdata_q    <= {bus.in_data, word_sr_q};
                            addr_q     <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            word_idx_q <= word_idx_q + 16'd1;
                            words_q    <= words_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = accepting;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign busy         = accepting;
    assign start        = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign words_loaded = words_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized program streams checked against a
// stream-level model (expected writes queue and final status).
module tb_imem_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        start;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;
    logic [2:0]  state_dbg;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .bus         (bus),
        .start       (start),
        .busy        (busy),
        .error       (error),
        .words_loaded(words_loaded),
        .state_dbg   (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          stalls  = 0;
    logic [79:0] exp_q[$];      // {word index, addr, data}
    int          wr_cyc_q[$];
    logic [31:0] wq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called once per cycle at the falling edge: scoreboard for memory writes.
    task automatic sample();
        logic [79:0] e;
        cyc++;
        if (bus.imem_we === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'd0, bus.imem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", bus.imem_addr, e[63:32]);
                check("we_data", bus.imem_wdata, e[31:0]);
                check("we_count", {16'd0, words_loaded}, {16'd0, e[79:64]} + 32'd1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        sample();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            bus.in_data = 8'($urandom);
            tick();
        end
    endtask

    // driver
    task automatic send_byte(input logic [7:0] b, input bit lreq);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        load_req     = lreq;
        while (!bus.in_ready && guard < 16) begin
            stalls++;
            guard++;
            tick();
            load_req = 1'b0;
        end
        if (guard >= 16) check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        load_req     = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_we"},       {31'd0, bus.imem_we},  32'd0);
        check({tag, "_addr"},     bus.imem_addr,         BASE);
        check({tag, "_wdata"},    bus.imem_wdata,        32'd0);
        check({tag, "_start"},    {31'd0, start},        32'd0);
        check({tag, "_busy"},     {31'd0, busy},         32'd0);
        check({tag, "_error"},    {31'd0, error},        32'd0);
        check({tag, "_words"},    {16'd0, words_loaded}, 32'd0);
    endtask

    // Build the stream for wq[0..n-1] from the format rules, predict writes and status, drive it.
    task automatic run_load(input int n, input bit corrupt, input int gap_pct,
                            input int hold_at, input int lreq_at);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [31:0] w;
        bit          too_big;
        bit          ok;
        int          base;
        too_big = (n > DEPTH);
        cs      = 8'd0;
        bytes.push_back(8'(n));
        bytes.push_back(8'(n >> 8));
        if (!too_big) begin
            for (int k = 0; k < n; k++) begin
                w = wq[k];
                for (int j = 0; j < 4; j++) begin
                    bytes.push_back(w[8*j +: 8]);
                    cs = cs ^ w[8*j +: 8];
                end
                exp_q.push_back({16'(k), BASE + 32'(4 * k), w});
            end
            bytes.push_back(corrupt ? cs + 8'd1 : cs);
        end
        ok     = !too_big && !corrupt;
        base   = wr_cyc_q.size();
        stalls = 0;

        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("lr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("lr_busy",     {31'd0, busy},         32'd1);
        check("lr_start",    {31'd0, start},        32'd0);
        check("lr_error",    {31'd0, error},        32'd0);
        check("lr_words",    {16'd0, words_loaded}, 32'd0);

        for (int i = 0; i < bytes.size(); i++) begin
            if (i == hold_at) idle(5);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
            send_byte(bytes[i], i == lreq_at);
        end

        check("end_start",    {31'd0, start},        {31'd0, ok});
        check("end_error",    {31'd0, error},        {31'd0, !ok});
        check("end_words",    {16'd0, words_loaded}, too_big ? 32'd0 : 32'(n));
        check("end_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("end_busy",     {31'd0, busy},         32'd0);
        check("end_pending",  32'(exp_q.size()),     32'd0);
        check("end_nwrites",  32'(wr_cyc_q.size() - base), too_big ? 32'd0 : 32'(n));

        if (gap_pct == 0 && hold_at < 0 && !too_big) begin
            check("full_rate_stalls", 32'(stalls), 32'd0);
            for (int k = base + 1; k < wr_cyc_q.size(); k++)
                check("write_spacing", 32'(wr_cyc_q[k] - wr_cyc_q[k-1]), 32'd4);
        end

        if (too_big) begin
            bus.in_valid = 1'b1;
            idle(6);
            bus.in_valid = 1'b0;
            check("big_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end

        idle(2);
        check("hold_start", {31'd0, start}, {31'd0, ok});
        check("hold_error", {31'd0, error}, {31'd0, !ok});
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        load_req     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        @(negedge clk);
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Single word 0x13.
        wq = '{32'h0000_0013};
        run_load(1, 1'b0, 0, -1, -1);

        // Three words at full rate.
        wq = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_load(3, 1'b0, 0, -1, -1);

        // Checksum off by one.
        wq = '{32'h1234_5678};
        run_load(1, 1'b1, 0, -1, -1);

        // Oversized lengths.
        run_load(257, 1'b0, 0, -1, -1);
        run_load(65535, 1'b0, 0, -1, -1);

        // Empty program, then restart from DONE with a stall and an ignored load_req mid-word.
        run_load(0, 1'b0, 0, -1, -1);
        wq = '{32'($urandom), 32'($urandom)};
        run_load(2, 1'b0, 0, 4, 3);

        // Exactly full memory.
        wq.delete();
        for (int k = 0; k < DEPTH; k++) wq.push_back(32'($urandom));
        run_load(DEPTH, 1'b0, 0, -1, -1);

        // Random programs.
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, 8);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(32'($urandom));
            run_load(n, ($urandom_range(0, 3) == 0), 30, -1,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * n + 2) : -1);
        end

        // Reset after two data bytes of a two-word load.
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_outputs("midload_reset");
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        idle(6);
        bus.in_valid = 1'b0;
        check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("post_reset_words",    {16'd0, words_loaded}, 32'd0);
        check("post_reset_we",       {31'd0, bus.imem_we},  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, is the maximum number of instruction words the target instruction memory holds.
REQ-002 Parameter BASE_ADDR, default 32'h0, is the byte address of the first word written.
REQ-003 Port clk, input, 1 bit: clock; all logic SHALL be rising-edge triggered.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port load_req, input, 1 bit: single-cycle request to begin a new program load.
REQ-006 Port in_valid, input, 1 bit: the byte on in_data is valid.
REQ-007 Port in_data, input, 8 bits: program stream byte.
REQ-008 Port in_ready, output, 1 bit: loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-009 Port imem_we, output, 1 bit: instruction memory write strobe.
REQ-010 Port imem_addr, output, 32 bits: instruction memory byte address.
REQ-011 Port imem_wdata, output, 32 bits: instruction word to write.
REQ-012 Port start, output, 1 bit: program loaded and verified; drives the pipeline start input.
REQ-013 Port busy, output, 1 bit: load in progress.
REQ-014 Port error, output, 1 bit: last load failed.
REQ-015 Port words_loaded, output, 16 bits: count of words written in the current or last load.

Function
REQ-016 Stream format SHALL be: 2-byte word count N (low byte first), then N*4 data bytes (each word little-endian, byte 0 first), then 1 checksum byte.
REQ-017 The checksum SHALL be the XOR of the N*4 data bytes; the length bytes are excluded, and N=0 expects checksum 8'h00.
REQ-018 FSM states SHALL be IDLE, LEN0, LEN1, DATA, CSUM, DONE and ERROR.
REQ-019 A load_req in IDLE, DONE or ERROR SHALL move the FSM to LEN0 and clear start, error, words_loaded and the running checksum.
REQ-020 load_req SHALL be ignored in LEN0, LEN1, DATA and CSUM.
REQ-021 in_ready SHALL be high exactly in LEN0, LEN1, DATA and CSUM; busy SHALL equal in_ready.
REQ-022 LEN0 SHALL latch the accepted byte as N[7:0] and go to LEN1; LEN1 SHALL latch N[15:8].
REQ-023 On leaving LEN1: if N > DEPTH_WORDS, go to ERROR; else if N = 0, go to CSUM; else go to DATA.
REQ-024 In DATA, a 2-bit byte counter SHALL assemble each word and XOR each accepted byte into the checksum.
REQ-025 The cycle after the 4th byte of word k is accepted, imem_we SHALL be high for exactly 1 cycle, with imem_addr = BASE_ADDR + 4*k and imem_wdata = {b3,b2,b1,b0}.
REQ-026 words_loaded SHALL increment in the same cycle imem_we is high.
REQ-027 Back-to-back bytes at full rate SHALL be accepted with no stall; the write of the last word may coincide with the checksum transfer.
REQ-028 After the 4th byte of word N-1 is accepted, the FSM SHALL go to CSUM.
REQ-029 In CSUM, the accepted byte SHALL be compared with the running checksum: on a match go to DONE, on a mismatch go to ERROR.
REQ-030 start SHALL be high in every cycle the FSM is in DONE, beginning the cycle after the checksum transfer, and remain high until reset or load_req.
REQ-031 error SHALL be high in every cycle the FSM is in ERROR.
REQ-032 imem_we SHALL be low whenever the FSM is in ERROR, DONE or IDLE.
REQ-033 Words already written before an ERROR SHALL NOT be rolled back.
REQ-034 imem_addr and imem_wdata SHALL hold their last values when imem_we is low.
REQ-035 in_valid without in_ready SHALL have no effect.

Reset
REQ-036 On reset the FSM SHALL go to IDLE and the following outputs SHALL clear: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, start=0, busy=0, error=0, words_loaded=0.
REQ-037 Reset SHALL clear the byte counter, N and the checksum.
REQ-038 Reset asserted mid-load SHALL abort the load, and no imem_we SHALL occur after reset is sampled.

Verification
REQ-039 load_req; stream 01 00 13 00 00 00 13 -> one imem_we with addr 0 and wdata 32'h00000013; start=1 the cycle after the last byte; words_loaded=1.
REQ-040 N=3 at full rate with data words 0x00500093, 0x00A00113, 0x002081B3 and the correct checksum -> writes to addr 0, 4 and 8 on consecutive 4-cycle spacing, in_ready never low, start=1.
REQ-041 N=1 with a checksum byte off by one -> error=1, start=0, the word is still written, words_loaded=1.
REQ-042 Length bytes 01 01 (N=257 > 256) -> ERROR after LEN1, no imem_we at all, further in_data ignored (in_ready=0).
REQ-043 N=0 with checksum 00 -> start=1 and no writes; reset asserted after 2 data bytes of an N=2 load -> all outputs at reset values and no further writes.
REQ-044 load_req issued in DONE restarts a load with start dropping the next cycle; load_req issued during DATA is ignored, and in_valid held low for 5 cycles mid-word corrupts nothing.
